// File: rtl/iec_sd_arbiter_if.sv
// iec_sd_arbiter_if: per-drive request bundle and shared SD host channel
interface iec_sd_arbiter_if #(
  parameter int NDR   = 4,
  parameter int LBA_W = 32,
  parameter int CNT_W = 6
);
  logic [NDR-1:0]       drv_rd;
  logic [NDR-1:0]       drv_wr;
  logic [NDR-1:0]       drv_ack;
  logic [NDR*LBA_W-1:0] drv_lba;
  logic [NDR*CNT_W-1:0] drv_blk_cnt;
  logic [NDR*8-1:0]     drv_buff_din;
  logic                 host_rd;
  logic                 host_wr;
  logic                 host_ack;
  logic [LBA_W-1:0]     host_lba;
  logic [CNT_W-1:0]     host_blk_cnt;
  logic [7:0]           host_buff_din;
  modport master (
    input  drv_rd, drv_wr, drv_lba, drv_blk_cnt, drv_buff_din, host_ack,
    output drv_ack, host_rd, host_wr, host_lba, host_blk_cnt, host_buff_din
  );
  modport slave (
    output drv_rd, drv_wr, drv_lba, drv_blk_cnt, drv_buff_din, host_ack,
    input  drv_ack, host_rd, host_wr, host_lba, host_blk_cnt, host_buff_din
  );
endinterface

// File: rtl/iec_sd_arbiter.sv
// iec_sd_arbiter: round-robin sharing of one SD block channel among several drives
module iec_sd_arbiter #(
  parameter int DRIVES  = 4,
  parameter int LBA_W   = 32,
  parameter int CNT_W   = 6,
  parameter int TIMEOUT = 0,
  localparam int NDR = DRIVES,
  localparam int IW  = (NDR > 1) ? $clog2(NDR) : 1
) (
  input  logic              clk_sys,
  input  logic              reset,
  iec_sd_arbiter_if.master  bus,
  output logic              busy,
  output logic [IW-1:0]     cur_drv,
  output logic              timeout_err
);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, REQ, XFER, REL} state_t;
  state_t         state;
  logic [IW-1:0]  rr;
  logic [IW-1:0]  win;
  logic [IW-1:0]  nxt;
  logic           found;
  logic           expired;
  logic [NDR-1:0] req;
  logic [TW-1:0]  tcnt;
  assign req     = bus.drv_rd | bus.drv_wr;
  assign nxt     = (cur_drv == IW'(NDR - 1)) ? '0 : cur_drv + 1'b1;
  assign expired = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
  assign busy    = state != IDLE;
  assign bus.drv_ack       = (busy && bus.host_ack) ? (NDR'(1) << cur_drv) : '0;
  assign bus.host_buff_din = busy ? bus.drv_buff_din[cur_drv*8 +: 8] : 8'h00;
  // first requester at or after rr; scanning downward lets the nearest one overwrite
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int j = NDR - 1; j >= 0; j--) begin
      if (req[(int'(rr) + j) % NDR]) begin
        found = 1'b1;
        win   = IW'((int'(rr) + j) % NDR);
      end
    end
  end
  // grant / request / transfer / release sequencing with registered host outputs
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state            <= IDLE;
      rr               <= '0;
      cur_drv          <= '0;
      tcnt             <= '0;
      timeout_err      <= 1'b0;
      bus.host_rd      <= 1'b0;
      bus.host_wr      <= 1'b0;
      bus.host_lba     <= '0;
      bus.host_blk_cnt <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: if (found) begin
          state            <= REQ;
          cur_drv          <= win;
          tcnt             <= '0;
          bus.host_lba     <= bus.drv_lba[win*LBA_W +: LBA_W];
          bus.host_blk_cnt <= bus.drv_blk_cnt[win*CNT_W +: CNT_W];
          bus.host_rd      <= bus.drv_rd[win];
          bus.host_wr      <= ~bus.drv_rd[win];
        end
        REQ: begin
          tcnt <= tcnt + 1'b1;
          if (bus.host_ack) begin
            state       <= XFER;
            bus.host_rd <= 1'b0;
            bus.host_wr <= 1'b0;
          end else if (!req[cur_drv] || expired) begin
            state       <= IDLE;
            rr          <= nxt;
            bus.host_rd <= 1'b0;
            bus.host_wr <= 1'b0;
            timeout_err <= req[cur_drv];
          end
        end
        XFER: if (!bus.host_ack) state <= REL;
        REL: begin
          state <= IDLE;
          rr    <= nxt;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_iec_sd_arbiter.sv
// tb_iec_sd_arbiter: directed and randomized checks against a transaction-level model
module tb_iec_sd_arbiter;
  localparam int N  = 4;
  localparam int LW = 32;
  localparam int CW = 6;
  localparam int TO = 16;

  logic       clk_sys = 1'b0;
  logic       reset   = 1'b1;
  logic       busy;
  logic [1:0] cur_drv;
  logic       timeout_err;

  iec_sd_arbiter_if #(.NDR(N), .LBA_W(LW), .CNT_W(CW)) bus();

  iec_sd_arbiter #(.DRIVES(N), .LBA_W(LW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk_sys     (clk_sys),
    .reset       (reset),
    .bus         (bus),
    .busy        (busy),
    .cur_drv     (cur_drv),
    .timeout_err (timeout_err)
  );

  always #5 clk_sys = ~clk_sys;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  // m_ph: 0 no owner, 1 waiting for host ack, 2 host acking, 3 release cycle
  int              m_ph, m_idx, m_rr, m_age;
  logic [LW-1:0]   m_lba;
  logic [CW-1:0]   m_cnt;
  logic            m_rd, m_wr, m_terr;

  function automatic int first_req(input logic [N-1:0] rq, input int rr);
    for (int j = 0; j < N; j++)
      if (rq[(rr + j) % N]) return (rr + j) % N;
    return -1;
  endfunction

  always @(posedge clk_sys) begin : model
    logic [N-1:0] rq;
    int w;
    rq = bus.drv_rd | bus.drv_wr;
    if (reset) begin
      m_ph = 0; m_rr = 0; m_idx = 0; m_age = 0;
      m_rd = 0; m_wr = 0; m_terr = 0; m_lba = '0; m_cnt = '0;
    end else begin
      m_terr = 0;
      if (m_ph == 0) begin
        w = first_req(rq, m_rr);
        if (w >= 0) begin
          m_idx = w;
          m_lba = bus.drv_lba[w*LW +: LW];
          m_cnt = bus.drv_blk_cnt[w*CW +: CW];
          m_rd  = bus.drv_rd[w];
          m_wr  = !bus.drv_rd[w];
          m_age = 0;
          m_ph  = 1;
        end
      end else if (m_ph == 1) begin
        if (bus.host_ack) begin
          m_rd = 0; m_wr = 0; m_ph = 2;
        end else if (!rq[m_idx] || m_age == TO - 1) begin
          m_terr = rq[m_idx];
          m_rd = 0; m_wr = 0; m_ph = 0; m_rr = (m_idx + 1) % N;
        end
        m_age++;
      end else if (m_ph == 2) begin
        if (!bus.host_ack) m_ph = 3;
      end else begin
        m_rr = (m_idx + 1) % N;
        m_ph = 0;
      end
    end
  end

  always @(negedge clk_sys) begin : compare
    logic [N-1:0] ea;
    logic [7:0]   ed;
    if (chk_en) begin
      ea = (m_ph != 0 && bus.host_ack) ? (N'(1) << m_idx) : '0;
      ed = (m_ph != 0) ? bus.drv_buff_din[m_idx*8 +: 8] : 8'h00;
      chk("m_host_rd", bus.host_rd, m_rd);
      chk("m_host_wr", bus.host_wr, m_wr);
      chk("m_busy", busy, m_ph != 0);
      chk("m_cur_drv", cur_drv, m_idx);
      chk("m_timeout_err", timeout_err, m_terr);
      chk("m_drv_ack", bus.drv_ack, ea);
      chk("m_host_buff_din", bus.host_buff_din, ed);
      chk("m_host_lba", bus.host_lba, m_lba);
      chk("m_host_blk_cnt", bus.host_blk_cnt, m_cnt);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic clr();
    bus.drv_rd = '0; bus.drv_wr = '0; bus.drv_lba = '0;
    bus.drv_blk_cnt = '0; bus.drv_buff_din = '0; bus.host_ack = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int order[6];
    int exp_order[6];
    int n, seen, k, hdelay, hhold;
    exp_order = '{0, 1, 3, 0, 1, 3};
    clr();
    @(posedge clk_sys);
    #1;
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_host_rd", bus.host_rd, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_cur_drv", cur_drv, 2'd0);
    chk("rst_drv_ack", bus.drv_ack, 4'b0000);

    // single read on drive 2
    bus.drv_rd[2] = 1'b1;
    bus.drv_lba[2*LW +: LW] = 32'h1234;
    bus.drv_blk_cnt[2*CW +: CW] = 6'd1;
    step();
    chk("rd_host_rd", bus.host_rd, 1'b1);
    chk("rd_host_lba", bus.host_lba, 32'h1234);
    chk("rd_cur_drv", cur_drv, 2'd2);
    chk("rd_blk_cnt", bus.host_blk_cnt, 6'd1);
    bus.host_ack = 1'b1;
    step();
    chk("rd_host_rd_drop", bus.host_rd, 1'b0);
    chk("rd_drv_ack", bus.drv_ack, 4'b0100);
    bus.drv_rd[2] = 1'b0;
    repeat (9) step();
    chk("rd_drv_ack_hold", bus.drv_ack, 4'b0100);
    bus.host_ack = 1'b0;
    step();
    chk("rd_busy_rel", busy, 1'b1);
    step();
    chk("rd_busy_idle", busy, 1'b0);

    // fairness among drives 0, 1, 3
    do_reset();
    bus.drv_rd[0] = 1'b1; bus.drv_rd[1] = 1'b1; bus.drv_rd[3] = 1'b1;
    for (int g = 0; g < 6; g++) begin
      for (int i = 0; i < 20 && bus.host_rd !== 1'b1; i++) step();
      chk("rr_grant_seen", bus.host_rd, 1'b1);
      order[g] = int'(cur_drv);
      bus.host_ack = 1'b1;
      step();
      step();
      bus.host_ack = 1'b0;
      step();
    end
    for (int g = 0; g < 6; g++) chk("rr_order", order[g], exp_order[g]);

    // read wins over write on the same drive
    do_reset();
    bus.drv_rd[1] = 1'b1; bus.drv_wr[1] = 1'b1;
    step();
    chk("rw_host_rd", bus.host_rd, 1'b1);
    chk("rw_host_wr", bus.host_wr, 1'b0);
    chk("rw_cur_drv", cur_drv, 2'd1);

    // write data path
    do_reset();
    bus.drv_wr[0] = 1'b1;
    bus.drv_buff_din[7:0] = 8'hA5;
    step();
    chk("wd_host_wr", bus.host_wr, 1'b1);
    chk("wd_din_req", bus.host_buff_din, 8'hA5);
    bus.host_ack = 1'b1;
    step();
    chk("wd_din_xfer", bus.host_buff_din, 8'hA5);
    bus.drv_wr[0] = 1'b0;
    bus.host_ack = 1'b0;
    step();
    step();
    chk("wd_idle_busy", busy, 1'b0);
    chk("wd_din_idle", bus.host_buff_din, 8'h00);

    // timeout with another drive pending
    do_reset();
    bus.drv_wr[3] = 1'b1;
    step();
    chk("to_host_wr", bus.host_wr, 1'b1);
    bus.drv_rd[0] = 1'b1;
    n = 0;
    while (timeout_err !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("to_cycles", n, 16);
    chk("to_host_wr_drop", bus.host_wr, 1'b0);
    step();
    chk("to_single_pulse", timeout_err, 1'b0);
    chk("to_next_grant", cur_drv, 2'd0);
    chk("to_next_rd", bus.host_rd, 1'b1);

    // withdrawal in REQ
    do_reset();
    bus.drv_rd[1] = 1'b1;
    step();
    chk("wd_grant", bus.host_rd, 1'b1);
    bus.drv_rd[1] = 1'b0;
    step();
    chk("wdr_host_rd", bus.host_rd, 1'b0);
    chk("wdr_busy", busy, 1'b0);
    seen = 0;
    repeat (20) begin
      step();
      if (timeout_err === 1'b1) seen++;
    end
    chk("wdr_no_timeout", seen, 0);

    // reset in the middle of a transfer
    bus.drv_rd[2] = 1'b1;
    step();
    bus.host_ack = 1'b1;
    step();
    reset = 1'b1;
    step();
    chk("rx_host_rd", bus.host_rd, 1'b0);
    chk("rx_busy", busy, 1'b0);
    chk("rx_cur_drv", cur_drv, 2'd0);
    chk("rx_drv_ack", bus.drv_ack, 4'b0000);
    chk("rx_host_lba", bus.host_lba, 32'h0);
    chk("rx_din", bus.host_buff_din, 8'h00);
    reset = 1'b0;
    bus.host_ack = 1'b0;
    bus.drv_rd = 4'b1001;
    step();
    chk("rx_first_drv0", cur_drv, 2'd0);

    // randomized traffic; the compare process checks every cycle
    do_reset();
    hdelay = -1;
    hhold  = 0;
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 399) == 0);
      for (int i = 0; i < N; i++) begin
        bus.drv_buff_din[i*8 +: 8] = 8'($urandom);
        if (bus.drv_ack[i]) begin
          bus.drv_rd[i] = 1'b0;
          bus.drv_wr[i] = 1'b0;
        end else if (!(bus.drv_rd[i] | bus.drv_wr[i])) begin
          if ($urandom_range(0, 5) == 0) begin
            k = $urandom_range(0, 3);
            bus.drv_rd[i] = (k != 1);
            bus.drv_wr[i] = (k != 0);
            bus.drv_lba[i*LW +: LW] = $urandom;
            bus.drv_blk_cnt[i*CW +: CW] = CW'($urandom);
          end
        end else if ($urandom_range(0, 79) == 0) begin
          bus.drv_rd[i] = 1'b0;
          bus.drv_wr[i] = 1'b0;
        end
      end
      if (bus.host_ack) begin
        if (hhold == 0) bus.host_ack = 1'b0;
        else hhold--;
      end else if (bus.host_rd | bus.host_wr) begin
        if (hdelay < 0) hdelay = $urandom_range(0, 19);
        if (hdelay == 0) begin
          bus.host_ack = 1'b1;
          hhold  = $urandom_range(0, 4);
          hdelay = -1;
        end else hdelay--;
      end else hdelay = -1;
      step();
    end
    clr();
    reset = 1'b0;
    repeat (5) step();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
